// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory-access stage: FSM state encodings, load
// funct3 codes, RIB request levels, register write-enable levels and the
// all-zero data word.
// -----------------------------------------------------------------------------
package mem_access_pkg;

   localparam int XLEN_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Load funct3 codes (inst[14:12])
   localparam logic [2:0] INST_LB  = 3'b000;
   localparam logic [2:0] INST_LH  = 3'b001;
   localparam logic [2:0] INST_LW  = 3'b010;
   localparam logic [2:0] INST_LBU = 3'b100;
   localparam logic [2:0] INST_LHU = 3'b101;

   localparam logic RIB_REQ       = 1'b1;
   localparam logic RIB_NREQ      = 1'b0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   localparam logic [XLEN_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Purely combinational load-data extraction: selects the byte/half addressed
// by the low address bits and sign- or zero-extends it according to funct3.
// Ports:
//   word   - captured bus read word
//   offset - load address bits [1:0]
//   funct3 - load type
//   result - extended XLEN-wide register value (zero for non-load codes)
// -----------------------------------------------------------------------------
module mem_load_align
   import mem_access_pkg::*;
#(
   parameter int XLEN = XLEN_W
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{offset, 3'b000} +: 8];
   assign half_sel = offset[1] ? word[31:16] : word[15:0];

   always_comb begin
      // NOTE: assign a default before the case so every path drives result;
      // otherwise an unlisted funct3 would infer a latch.
      result = XLEN'(ZERO_WORD);
      case (funct3)
         INST_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         INST_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
         INST_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
         INST_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
         INST_LW:  result = word;
         default:  ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory-access stage after the EX/MEM register. Runs one load or store per
// instruction on the RIB data bus (req/ack), stalls the pipeline while the
// transaction is outstanding, and presents the register-write triple to MEM/WB.
// FSM: IDLE (pass-through / detect) -> BUSY (wait for ack) -> DONE (one cycle).
//
// Optional build macro MEM_BUS_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter,
// an 8-bit BUSY wait counter and the bus_err_o pulse output.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   inst_i              - instruction (funct3 = inst_i[14:12])
//   reg_we/waddr/wdata_i- EX/MEM register-write triple
//   mem_req/we_i, mem_raddr/waddr/wdata/sel_i - memory request from EX/MEM
//   bus_*_o / bus_ack_i / bus_rdata_i - RIB data bus (outputs registered)
//   hold_req_o          - stall request to the pipeline controller
//   reg_we/waddr/wdata_o- register-write triple to MEM/WB
//   bus_err_o           - timeout pulse (MEM_BUS_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_access
   import mem_access_pkg::*;
#(
   parameter int XLEN = XLEN_W
`ifdef MEM_BUS_TIMEOUT_EN
   , parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst_i,
   input  logic            reg_we_i,
   input  logic [4:0]      reg_waddr_i,
   input  logic [XLEN-1:0] reg_wdata_i,
   input  logic            mem_req_i,
   input  logic            mem_we_i,
   input  logic [XLEN-1:0] mem_raddr_i,
   input  logic [XLEN-1:0] mem_waddr_i,
   input  logic [XLEN-1:0] mem_wdata_i,
   input  logic [3:0]      mem_sel_i,
   output logic            bus_req_o,
   output logic            bus_we_o,
   output logic [XLEN-1:0] bus_addr_o,
   output logic [XLEN-1:0] bus_wdata_o,
   output logic [3:0]      bus_sel_o,
   input  logic            bus_ack_i,
   input  logic [XLEN-1:0] bus_rdata_i,
`ifdef MEM_BUS_TIMEOUT_EN
   output logic            bus_err_o,
`endif
   output logic            hold_req_o,
   output logic            reg_we_o,
   output logic [4:0]      reg_waddr_o,
   output logic [XLEN-1:0] reg_wdata_o
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] load_data;
   logic            is_store;
   logic            timeout;   // BUSY gives up this cycle (never with an ack)
   logic            done_err;  // current DONE was reached by timeout

   // Only funct3 is needed from the instruction word.
   logic unused_inst;
   assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

   assign is_store = (mem_we_i == WRITE_ENABLE);

   mem_load_align #(.XLEN(XLEN)) u_load_align (
      .word   (rdata_q),
      .offset (mem_raddr_i[1:0]),
      .funct3 (inst_i[14:12]),
      .result (load_data)
   );

`ifdef MEM_BUS_TIMEOUT_EN
   logic [7:0] wait_cnt_q;
   logic       err_q;

   assign timeout   = (state_q == ST_BUSY) && !bus_ack_i &&
                      (wait_cnt_q == TIMEOUT_CYCLES - 8'd1);
   assign done_err  = err_q;
   assign bus_err_o = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         // err_q is high exactly during the DONE cycle that follows a timeout.
         err_q <= timeout;
         if (state_q == ST_IDLE && mem_req_i)
            wait_cnt_q <= 8'd0;
         else if (state_q == ST_BUSY && !bus_ack_i)
            wait_cnt_q <= wait_cnt_q + 8'd1;
      end
   end
`else
   assign timeout  = 1'b0;
   assign done_err = 1'b0;
`endif

   // Next state and stage outputs. Outside a transaction the EX/MEM triple
   // passes straight through.
   always_comb begin
      state_d     = state_q;
      hold_req_o  = 1'b0;
      reg_we_o    = reg_we_i;
      reg_waddr_o = reg_waddr_i;
      reg_wdata_o = reg_wdata_i;
      case (state_q)
         ST_IDLE: begin
            if (mem_req_i) begin
               hold_req_o = 1'b1;
               reg_we_o   = WRITE_DISABLE;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            hold_req_o = 1'b1;
            reg_we_o   = WRITE_DISABLE;
            if (bus_ack_i || timeout)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            // mem_req_i still reflects this instruction; never restart here.
            reg_we_o = reg_we_i && !is_store && !done_err;
            if (!is_store)
               reg_wdata_o = load_data;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_req_o   <= RIB_NREQ;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= XLEN'(ZERO_WORD);
         bus_wdata_o <= XLEN'(ZERO_WORD);
         bus_sel_o   <= 4'b0000;
         rdata_q     <= XLEN'(ZERO_WORD);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_req_i) begin
                  bus_req_o   <= RIB_REQ;
                  bus_we_o    <= mem_we_i;
                  bus_addr_o  <= is_store ? mem_waddr_i : mem_raddr_i;
                  bus_wdata_o <= mem_wdata_i;
                  bus_sel_o   <= is_store ? mem_sel_i : 4'b1111;
               end
            end
            ST_BUSY: begin
               if (bus_ack_i) begin
                  rdata_q   <= bus_rdata_i;
                  bus_req_o <= RIB_NREQ;
               end else if (timeout) begin
                  bus_req_o <= RIB_NREQ;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Table-driven bench for mem_access with a writeback scoreboard, plus hand
// sequences for reset, reset mid-transaction and (MEM_BUS_TIMEOUT_EN) timeout.
// -----------------------------------------------------------------------------
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i;
   logic        reg_we_i;
   logic [4:0]  reg_waddr_i;
   logic [31:0] reg_wdata_i;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [31:0] mem_raddr_i;
   logic [31:0] mem_waddr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_sel_i;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_sel_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        hold_req_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
`ifdef MEM_BUS_TIMEOUT_EN
   logic        bus_err_o;
`endif

   always #5 clk = ~clk;

`ifdef MEM_BUS_TIMEOUT_EN
   mem_access #(.XLEN(32), .TIMEOUT_CYCLES(8'd4)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_i      (inst_i),
      .reg_we_i    (reg_we_i),
      .reg_waddr_i (reg_waddr_i),
      .reg_wdata_i (reg_wdata_i),
      .mem_req_i   (mem_req_i),
      .mem_we_i    (mem_we_i),
      .mem_raddr_i (mem_raddr_i),
      .mem_waddr_i (mem_waddr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_sel_i   (mem_sel_i),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_sel_o   (bus_sel_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i),
      .bus_err_o   (bus_err_o),
      .hold_req_o  (hold_req_o),
      .reg_we_o    (reg_we_o),
      .reg_waddr_o (reg_waddr_o),
      .reg_wdata_o (reg_wdata_o)
   );
`else
   mem_access #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_i      (inst_i),
      .reg_we_i    (reg_we_i),
      .reg_waddr_i (reg_waddr_i),
      .reg_wdata_i (reg_wdata_i),
      .mem_req_i   (mem_req_i),
      .mem_we_i    (mem_we_i),
      .mem_raddr_i (mem_raddr_i),
      .mem_waddr_i (mem_waddr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_sel_i   (mem_sel_i),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_sel_o   (bus_sel_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i),
      .hold_req_o  (hold_req_o),
      .reg_we_o    (reg_we_o),
      .reg_waddr_o (reg_waddr_o),
      .reg_wdata_o (reg_wdata_o)
   );
`endif

   typedef struct {
      logic [2:0]  funct3;
      logic        reg_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] addr;
      logic [31:0] mem_wdata;
      logic [3:0]  sel;
      logic [31:0] rdata;
      int          wait_cycles;
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } wb_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];
   wb_t  sb [$];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic pop_and_check(input string tag);
      wb_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_reg_we"},    {31'd0, reg_we_o}, {31'd0, e.we});
      check({tag, "_reg_waddr"}, {27'd0, reg_waddr_o}, {27'd0, e.waddr});
      check({tag, "_reg_wdata"}, reg_wdata_o, e.wdata);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] inst;
      int          hold_cycles;
      string       tag;
      tag = $sformatf("v%0d", idx);
      inst = $urandom();
      inst[14:12] = v.funct3;
      @(posedge clk); #1;
      inst_i      = inst;
      reg_we_i    = v.reg_we;
      reg_waddr_i = v.waddr;
      reg_wdata_i = v.wdata;
      mem_req_i   = v.mem_req;
      mem_we_i    = v.mem_we;
      mem_raddr_i = v.mem_we ? (v.addr ^ 32'h5555_0000) : v.addr;
      mem_waddr_i = v.mem_we ? v.addr : (v.addr ^ 32'h0AA0_0000);
      mem_wdata_i = v.mem_wdata;
      mem_sel_i   = v.sel;
      bus_ack_i   = 1'b0;
      bus_rdata_i = $urandom();
      sb.push_back('{we: v.exp_we, waddr: v.waddr, wdata: v.exp_wdata});

      if (!v.mem_req) begin
         @(negedge clk);
         check({tag, "_hold"},    {31'd0, hold_req_o}, 32'd0);
         check({tag, "_bus_req"}, {31'd0, bus_req_o},  32'd0);
         pop_and_check(tag);
      end else begin
         hold_cycles = 0;
         @(negedge clk);
         while (hold_req_o && hold_cycles < 64) begin
            hold_cycles++;
            if (hold_cycles == 1) begin
               check({tag, "_idle_req"}, {31'd0, bus_req_o}, 32'd0);
               check({tag, "_idle_we"},  {31'd0, reg_we_o},  32'd0);
            end
            if (hold_cycles == 2) begin
               check({tag, "_bus_req"},  {31'd0, bus_req_o}, 32'd1);
               check({tag, "_bus_we"},   {31'd0, bus_we_o},  {31'd0, v.mem_we});
               check({tag, "_bus_addr"}, bus_addr_o, v.addr);
               check({tag, "_bus_sel"},  {28'd0, bus_sel_o},
                     {28'd0, (v.mem_we ? v.sel : 4'b1111)});
               if (v.mem_we)
                  check({tag, "_bus_wdata"}, bus_wdata_o, v.mem_wdata);
            end
            @(posedge clk); #1;
            bus_ack_i   = (hold_cycles - 1 == v.wait_cycles);
            bus_rdata_i = bus_ack_i ? v.rdata : $urandom();
            @(negedge clk);
         end
         bus_ack_i = 1'b0;
         check({tag, "_hold_cycles"}, hold_cycles, v.wait_cycles + 2);
         check({tag, "_done_req"}, {31'd0, bus_req_o}, 32'd0);
         pop_and_check(tag);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           f3     we    wa     wdata         req   mwe   addr          mwdata        sel      rdata         wait exp_we exp_wdata
      vecs[0]  = '{3'b000, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    32'h0,        0,   1'b1,  32'h0000_1234};
      vecs[1]  = '{3'b000, 1'b1, 5'd7,  32'h0,         1'b1, 1'b0, 32'h0000_0103, 32'h0,       4'h0,    32'h80FF_FFFF, 2,  1'b1,  32'hFFFF_FF80};
      vecs[2]  = '{3'b000, 1'b0, 5'd3,  32'h0000_CAFE, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    32'h0,        0,   1'b0,  32'h0000_CAFE};
      vecs[3]  = '{3'b101, 1'b1, 5'd8,  32'h0,         1'b1, 1'b0, 32'h0000_0102, 32'h0,       4'h0,    32'hBEEF_0000, 0,  1'b1,  32'h0000_BEEF};
      vecs[4]  = '{3'b010, 1'b1, 5'd2,  32'h0000_0011, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF,  32'h0,        0,   1'b0,  32'h0000_0011};
      vecs[5]  = '{3'b000, 1'b1, 5'd1,  32'hFFFF_0001, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    32'h0,        0,   1'b1,  32'hFFFF_0001};
      vecs[6]  = '{3'b010, 1'b1, 5'd9,  32'h0,         1'b1, 1'b0, 32'h0000_0104, 32'h0,       4'h0,    32'h1234_5678, 1,  1'b1,  32'h1234_5678};
      vecs[7]  = '{3'b100, 1'b1, 5'd10, 32'h0,         1'b1, 1'b0, 32'h0000_0101, 32'h0,       4'h0,    32'h0000_A500, 0,  1'b1,  32'h0000_00A5};
      vecs[8]  = '{3'b001, 1'b1, 5'd11, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 32'h0,       4'h0,    32'h0000_8001, 3,  1'b1,  32'hFFFF_8001};
      vecs[9]  = '{3'b001, 1'b1, 5'd12, 32'h0,         1'b1, 1'b0, 32'h0000_0102, 32'h0,       4'h0,    32'hFFFE_0000, 0,  1'b1,  32'hFFFF_FFFE};
      vecs[10] = '{3'b000, 1'b1, 5'd13, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 32'h0,       4'h0,    32'h0000_007F, 0,  1'b1,  32'h0000_007F};
      vecs[11] = '{3'b011, 1'b1, 5'd14, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 32'h0,       4'h0,    32'hFFFF_FFFF, 0,  1'b1,  32'h0000_0000};
      vecs[12] = '{3'b010, 1'b0, 5'd15, 32'h0,         1'b1, 1'b0, 32'h0000_0108, 32'h0,       4'h0,    32'hA5A5_A5A5, 1,  1'b0,  32'hA5A5_A5A5};
      vecs[13] = '{3'b000, 1'b0, 5'd16, 32'h0000_0022, 1'b1, 1'b1, 32'h0000_0301, 32'h0000_AB00, 4'b0010, 32'h0,     2,   1'b0,  32'h0000_0022};
      vecs[14] = '{3'b000, 1'b1, 5'd31, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    32'h0,        0,   1'b1,  32'h0};

      // Reset state
      rst = 1'b0;
      inst_i = '0; reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_raddr_i = '0; mem_waddr_i = '0;
      mem_wdata_i = '0; mem_sel_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
      #12;
      check("rst_bus_req",   {31'd0, bus_req_o}, 32'd0);
      check("rst_bus_we",    {31'd0, bus_we_o},  32'd0);
      check("rst_bus_addr",  bus_addr_o, 32'd0);
      check("rst_bus_wdata", bus_wdata_o, 32'd0);
      check("rst_bus_sel",   {28'd0, bus_sel_o}, 32'd0);
      check("rst_hold",      {31'd0, hold_req_o}, 32'd0);
`ifdef MEM_BUS_TIMEOUT_EN
      check("rst_bus_err",   {31'd0, bus_err_o}, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++)
         run_vec(vecs[i], i);

      // Reset while BUSY: bus_req_o must drop without waiting for a clock.
      @(posedge clk); #1;
      inst_i = 32'h0000_2003; reg_we_i = 1'b1; reg_waddr_i = 5'd20; reg_wdata_i = '0;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_raddr_i = 32'h0000_0400; bus_ack_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rstmid_busy_req", {31'd0, bus_req_o}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rstmid_async_req", {31'd0, bus_req_o}, 32'd0);
      check("rstmid_addr",      bus_addr_o, 32'd0);
      check("rstmid_no_wb",     {31'd0, reg_we_o}, 32'd0);
      mem_req_i = 1'b0; reg_we_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      // Back in IDLE: pass-through works and a stray ack is ignored.
      bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
      reg_we_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'h0000_0099;
      @(negedge clk);
      check("rstmid_idle_hold", {31'd0, hold_req_o}, 32'd0);
      check("rstmid_idle_we",   {31'd0, reg_we_o}, 32'd1);
      check("rstmid_idle_wa",   {27'd0, reg_waddr_o}, 32'd9);
      check("rstmid_idle_wd",   reg_wdata_o, 32'h0000_0099);
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      @(negedge clk);
      check("rstmid_ack_ignored", {31'd0, bus_req_o}, 32'd0);

`ifdef MEM_BUS_TIMEOUT_EN
      begin
         int err_count;
         int first_k;
         err_count = 0;
         first_k   = -1;
         @(posedge clk); #1;
         inst_i = 32'h0000_2003; reg_we_i = 1'b1; reg_waddr_i = 5'd21;
         mem_req_i = 1'b1; mem_we_i = 1'b0; mem_raddr_i = 32'h0000_0500; bus_ack_i = 1'b0;
         @(posedge clk);  // BUSY entry
         for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_err_o) begin
               err_count++;
               if (first_k < 0) begin
                  first_k = k;
                  check("to_done_we",   {31'd0, reg_we_o},   32'd0);
                  check("to_done_req",  {31'd0, bus_req_o},  32'd0);
                  check("to_done_hold", {31'd0, hold_req_o}, 32'd0);
                  mem_req_i = 1'b0;
               end
            end
         end
         check("to_err_count", err_count, 32'd1);
         check("to_err_cycle", first_k,   32'd4);
      end
`endif

      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX results and runs one load or store per instruction on the RIB-style data bus using a req/ack handshake.
- Holds the pipeline while the bus transaction is outstanding.
- Extracts and sign/zero-extends load data, then presents the final register-write triple to the MEM/WB register.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 255, bus-ack timeout limit; used only with the optional feature; width 8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- inst_i  in  32  instruction from EX/MEM; funct3 = inst_i[14:12]
- reg_we_i  in  1  register write enable from EX/MEM
- reg_waddr_i  in  5  destination register
- reg_wdata_i  in  XLEN  ALU result for non-load instructions
- mem_req_i  in  1  memory access request
- mem_we_i  in  1  1 = store, 0 = load
- mem_raddr_i  in  XLEN  load address
- mem_waddr_i  in  XLEN  store address
- mem_wdata_i  in  XLEN  store data, already lane-aligned
- mem_sel_i  in  4  byte-lane strobes
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  bus write, registered
- bus_addr_o  out  XLEN  bus address, registered
- bus_wdata_o  out  XLEN  bus write data, registered
- bus_sel_o  out  4  bus strobes, registered
- bus_ack_i  in  1  bus acknowledge; bus_rdata_i valid in the same cycle
- bus_rdata_i  in  XLEN  bus read data
- hold_req_o  out  1  stall request to the pipeline controller
- reg_we_o  out  1  write enable to MEM/WB
- reg_waddr_o  out  5  destination register to MEM/WB
- reg_wdata_o  out  XLEN  write data to MEM/WB
- bus_err_o  out  1  timeout pulse; present only with the optional feature

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All bus_* outputs 0; captured read data 0; bus_err_o 0.
  - Reset mid-transaction drops bus_req_o immediately; no writeback occurs.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_req_i=0: combinational pass-through, zero latency. reg_we_o/waddr/wdata = inputs; hold_req_o=0.
  - mem_req_i=1:
    - hold_req_o=1 combinationally, so EX/MEM holds its contents.
    - reg_we_o=0.
    - Next edge: latch bus_addr_o (mem_waddr_i if mem_we_i, else mem_raddr_i), bus_we_o, bus_wdata_o, bus_sel_o (4'b1111 for loads); set bus_req_o=1; go to BUSY.
- BUSY:
  - bus_req_o stays 1; hold_req_o=1; reg_we_o=0.
  - bus_ack_i=1: capture bus_rdata_i; clear bus_req_o next edge; go to DONE.
  - bus_ack_i in IDLE or DONE is ignored.
- DONE (exactly one cycle):
  - hold_req_o=0, so EX/MEM advances at the end of this cycle.
  - Outputs: reg_waddr_o = reg_waddr_i; reg_we_o = reg_we_i and not mem_we_i.
  - Load: reg_wdata_o = extracted captured data. Store: reg_wdata_o = reg_wdata_i.
  - mem_req_i still reads 1 for the same instruction and must not restart: DONE always goes to IDLE.
- Load extraction, offset = mem_raddr_i[1:0]:
  - LB (000): sign-extend byte[offset]. LBU (100): zero-extend byte[offset].
  - LH (001): sign-extend half[offset[1]]. LHU (101): zero-extend half[offset[1]].
  - LW (010): full word.
  - Any other funct3: zero.
- Minimum memory latency is 3 cycles (IDLE detect, BUSY with the earliest ack, DONE); each extra wait cycle adds one.
- Back-to-back memory instructions re-enter BUSY from IDLE; there is no bubble insertion beyond the DONE→IDLE cycle.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on BUSY entry and increments every BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop bus_req_o, pulse bus_err_o for one cycle, go to DONE with reg_we_o forced to 0.
  - A simultaneous ack on the timeout cycle wins: normal completion, no error.
- Undefined: no counter and no bus_err_o port; BUSY waits indefinitely.

Decomposition:
- Shared defines header holds: state encodings; load funct3 codes (LB/LH/LW/LBU/LHU); RIB_REQ/RIB_NREQ; WriteEnable/WriteDisable; ZeroWord.
- One natural sub-module: mem_load_align. Purely combinational: captured word, offset and funct3 in, extended XLEN result out.

Test Plan:
- Non-memory pass-through: reg_we_i=1, waddr=5, wdata=0x1234, mem_req_i=0 → same-cycle reg_we_o=1, waddr 5, data 0x1234; hold_req_o=0; bus_req_o stays 0.
- LB with sign: raddr=0x103, inst funct3=000, ack after 2 wait cycles with rdata=0x80FFFFFF → hold_req_o high 4 cycles, then DONE reg_wdata_o=0xFFFFFF80.
- LHU: raddr=0x102, funct3=101, immediate ack, rdata=0xBEEF0000 → DONE reg_wdata_o=0x0000BEEF; total 3 cycles.
- SW: waddr=0x200, wdata=0xDEADBEEF, sel=4'b1111 → bus_we_o=1, bus_addr_o=0x200, bus_sel_o=4'b1111 while req; DONE reg_we_o=0.
- Reset mid-transaction: rst low while in BUSY → bus_req_o=0 asynchronously; after release, state IDLE and no writeback.
- With MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives → bus_err_o pulses exactly once 4 cycles after BUSY entry; reg_we_o=0 in DONE; bus_req_o drops.
